// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one combinational adder between two requesters.
// Operands and result are registered; one operation is in flight at a time.
module adder_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Req0Valid,
    input  logic [WIDTH-1:0] Req0A,
    input  logic [WIDTH-1:0] Req0B,
    output logic             Req0Ready,
    output logic             Resp0Valid,
    input  logic             Resp0Ready,
    input  logic             Req1Valid,
    input  logic [WIDTH-1:0] Req1A,
    input  logic [WIDTH-1:0] Req1B,
    output logic             Req1Ready,
    output logic             Resp1Valid,
    input  logic             Resp1Ready,
    output logic [WIDTH-1:0] RespSum,
    output logic             RespCarry,
    output logic [WIDTH-1:0] AdderA,
    output logic [WIDTH-1:0] AdderB,
    input  logic [WIDTH-1:0] AdderSum,
    input  logic             AdderCarry,
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_grant;
    logic   owner;
    logic   grant;
    logic   accept;
    logic   resp_take;

    // Winner is the sole valid port, or the port not granted last time.
    always_comb begin
        grant = 1'b0;
        if (Req0Valid && Req1Valid) begin
            grant = ~last_grant;
        end else if (Req1Valid) begin
            grant = 1'b1;
        end
    end

    assign accept    = (state == IDLE) && (Req0Valid || Req1Valid);
    assign resp_take = owner ? Resp1Ready : Resp0Ready;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    if (resp_take) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Req0Ready  = 1'b0;
        Req1Ready  = 1'b0;
        Resp0Valid = 1'b0;
        Resp1Valid = 1'b0;
        Busy       = (state != IDLE);
        if (state == IDLE) begin
            Req0Ready = Req0Valid && !grant;
            Req1Ready = Req1Valid && grant;
        end
        if (state == DONE) begin
            Resp0Valid = !owner;
            Resp1Valid = owner;
        end
    end

    // Operand capture on request handshake, result capture after the adder settles.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            AdderA     <= '0;
            AdderB     <= '0;
            RespSum    <= '0;
            RespCarry  <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                AdderA     <= grant ? Req1A : Req0A;
                AdderB     <= grant ? Req1B : Req0B;
                owner      <= grant;
                last_grant <= grant;
            end
            if (state == EXEC) begin
                RespSum   <= AdderSum;
                RespCarry <= AdderCarry;
            end
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed and randomised checks of adder_arbiter with a behavioural adder attached.
module tb_adder_arbiter;

    localparam int unsigned W = 32;

    logic         Clock;
    logic         Reset;
    logic         Req0Valid, Req0Ready, Resp0Valid, Resp0Ready;
    logic         Req1Valid, Req1Ready, Resp1Valid, Resp1Ready;
    logic [W-1:0] Req0A, Req0B, Req1A, Req1B;
    logic [W-1:0] RespSum, AdderA, AdderB, AdderSum;
    logic         RespCarry, AdderCarry, Busy;

    int checks;
    int failures;

    adder_arbiter #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req0Valid(Req0Valid), .Req0A(Req0A), .Req0B(Req0B), .Req0Ready(Req0Ready),
        .Resp0Valid(Resp0Valid), .Resp0Ready(Resp0Ready),
        .Req1Valid(Req1Valid), .Req1A(Req1A), .Req1B(Req1B), .Req1Ready(Req1Ready),
        .Resp1Valid(Resp1Valid), .Resp1Ready(Resp1Ready),
        .RespSum(RespSum), .RespCarry(RespCarry),
        .AdderA(AdderA), .AdderB(AdderB),
        .AdderSum(AdderSum), .AdderCarry(AdderCarry),
        .Busy(Busy)
    );

    // The attached shared adder.
    assign {AdderCarry, AdderSum} = {1'b0, AdderA} + {1'b0, AdderB};

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_inputs();
        Req0Valid = 1'b0; Req0A = '0; Req0B = '0; Resp0Ready = 1'b0;
        Req1Valid = 1'b0; Req1A = '0; Req1B = '0; Resp1Ready = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({Busy, Req0Ready, Req1Ready, Resp0Valid, Resp1Valid, RespCarry} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {Busy, Req0Ready, Req1Ready, Resp0Valid, Resp1Valid, RespCarry});
        end
        checks++;
        if ({AdderA, AdderB, RespSum} !== 96'h0) begin
            failures++;
            $display("FAIL reset_data: got A=%h B=%h sum=%h expected zeros", AdderA, AdderB, RespSum);
        end
    endtask

    task automatic test_port0_basic();
        apply_reset();
        Req0Valid = 1'b1; Req0A = 32'h0000_0004; Req0B = 32'h0040_0000;
        #1;
        checks++;
        if ({Req0Ready, Req1Ready} !== 2'b10) begin
            failures++;
            $display("FAIL p0_ready: got %b expected 10", {Req0Ready, Req1Ready});
        end
        tick();
        clear_inputs();
        checks++;
        if ({Busy, Resp0Valid, AdderA, AdderB} !== {2'b10, 32'h0000_0004, 32'h0040_0000}) begin
            failures++;
            $display("FAIL p0_exec: got busy=%b rv=%b A=%h B=%h expected 1 0 00000004 00400000",
                     Busy, Resp0Valid, AdderA, AdderB);
        end
        tick();
        checks++;
        if ({Resp0Valid, Resp1Valid, RespCarry, RespSum} !== {3'b100, 32'h0040_0004}) begin
            failures++;
            $display("FAIL p0_resp: got rv0=%b rv1=%b c=%b sum=%h expected 1 0 0 00400004",
                     Resp0Valid, Resp1Valid, RespCarry, RespSum);
        end
        Resp0Ready = 1'b1;
        tick();
        Resp0Ready = 1'b0;
        checks++;
        if ({Busy, Resp0Valid} !== 2'b00) begin
            failures++;
            $display("FAIL p0_release: got busy=%b rv0=%b expected 0 0", Busy, Resp0Valid);
        end
    endtask

    task automatic test_port1_carry();
        apply_reset();
        Req1Valid = 1'b1; Req1A = 32'hFFFF_FFFF; Req1B = 32'h0000_0001;
        #1;
        checks++;
        if ({Req0Ready, Req1Ready} !== 2'b01) begin
            failures++;
            $display("FAIL p1_ready: got %b expected 01", {Req0Ready, Req1Ready});
        end
        tick();
        clear_inputs();
        tick();
        checks++;
        if ({Resp0Valid, Resp1Valid, RespCarry, RespSum} !== {3'b011, 32'h0000_0000}) begin
            failures++;
            $display("FAIL p1_carry: got rv0=%b rv1=%b c=%b sum=%h expected 0 1 1 00000000",
                     Resp0Valid, Resp1Valid, RespCarry, RespSum);
        end
        Resp1Ready = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [W-1:0] a0 [4];
        logic [W-1:0] b0 [4];
        logic [W-1:0] a1 [4];
        logic [W-1:0] b1 [4];
        logic [W:0]   exp_val;
        int           n0, n1, nresp, ngrant, last_cyc, exp_port;
        a0 = '{32'h0000_0001, 32'h7FFF_FFFF, 32'hFFFF_0000, 32'h1234_5678};
        b0 = '{32'h0000_0002, 32'h0000_0001, 32'h0001_0000, 32'h8765_4321};
        a1 = '{32'h0000_0010, 32'hFFFF_FFFF, 32'h8000_0000, 32'hDEAD_BEEF};
        b1 = '{32'h0000_0020, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
        n0 = 0; n1 = 0; nresp = 0; ngrant = 0; last_cyc = 0; exp_port = 0; exp_val = '0;
        apply_reset();
        Resp0Ready = 1'b1;
        Resp1Ready = 1'b1;
        for (int cyc = 0; cyc < 60 && nresp < 8; cyc++) begin
            Req0Valid = (n0 < 4);
            Req1Valid = (n1 < 4);
            if (n0 < 4) begin Req0A = a0[n0]; Req0B = b0[n0]; end
            if (n1 < 4) begin Req1A = a1[n1]; Req1B = b1[n1]; end
            #1;
            if (Req0Ready || Req1Ready) begin
                checks++;
                if ({Req0Ready, Req1Ready} !== ((ngrant % 2 == 0) ? 2'b10 : 2'b01)) begin
                    failures++;
                    $display("FAIL rr_order: grant %0d got %b expected port %0d",
                             ngrant, {Req0Ready, Req1Ready}, ngrant % 2);
                end
                if (ngrant > 0) begin
                    checks++;
                    if (cyc - last_cyc !== 3) begin
                        failures++;
                        $display("FAIL rr_spacing: got %0d cycles expected 3", cyc - last_cyc);
                    end
                end
                exp_port = Req1Ready ? 1 : 0;
                exp_val  = Req1Ready ? ({1'b0, Req1A} + {1'b0, Req1B})
                                     : ({1'b0, Req0A} + {1'b0, Req0B});
                if (Req0Ready) n0++;
                if (Req1Ready) n1++;
                last_cyc = cyc;
                ngrant++;
            end
            if (Resp0Valid || Resp1Valid) begin
                checks++;
                if ({Resp1Valid, Resp0Valid, RespCarry, RespSum} !==
                    {(exp_port == 1), (exp_port == 0), exp_val}) begin
                    failures++;
                    $display("FAIL rr_result: got rv1=%b rv0=%b %h expected port %0d %h",
                             Resp1Valid, Resp0Valid, {RespCarry, RespSum}, exp_port, exp_val);
                end
                nresp++;
            end
            tick();
        end
        checks++;
        if (nresp !== 8) begin
            failures++;
            $display("FAIL rr_count: got %0d responses expected 8", nresp);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_backpressure();
        apply_reset();
        Req0Valid = 1'b1; Req0A = 32'h0000_1000; Req0B = 32'h0000_0234;
        Req1Valid = 1'b1; Req1A = 32'h0000_0003; Req1B = 32'h0000_0004;
        #1;
        checks++;
        if ({Req0Ready, Req1Ready} !== 2'b10) begin
            failures++;
            $display("FAIL bp_first: got %b expected 10", {Req0Ready, Req1Ready});
        end
        tick();
        Req0Valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({Resp0Valid, Req1Ready, RespCarry, RespSum} !== {3'b100, 32'h0000_1234}) begin
                failures++;
                $display("FAIL bp_hold: cycle %0d got rv0=%b rdy1=%b %h expected 1 0 000001234",
                         i, Resp0Valid, Req1Ready, {RespCarry, RespSum});
            end
            tick();
        end
        Resp0Ready = 1'b1;
        #1;
        checks++;
        if (Req1Ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_early_grant: got %b expected 0", Req1Ready);
        end
        tick();
        Resp0Ready = 1'b0;
        #1;
        checks++;
        if ({Req0Ready, Req1Ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_grant1: got %b expected 01", {Req0Ready, Req1Ready});
        end
        tick();
        Req1Valid = 1'b0;
        tick();
        checks++;
        if ({Resp1Valid, RespCarry, RespSum} !== {2'b10, 32'h0000_0007}) begin
            failures++;
            $display("FAIL bp_resp1: got rv1=%b %h expected 1 000000007",
                     Resp1Valid, {RespCarry, RespSum});
        end
        Resp1Ready = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_abort();
        logic seen;
        apply_reset();
        Req1Valid = 1'b1; Req1A = 32'h0000_0005; Req1B = 32'h0000_0006;
        tick();
        Req1Valid = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if ({Busy, Resp0Valid, Resp1Valid, RespCarry, AdderA, AdderB, RespSum} !== 100'h0) begin
            failures++;
            $display("FAIL abort_exec: got busy=%b rv=%b%b A=%h B=%h %h expected zeros",
                     Busy, Resp0Valid, Resp1Valid, AdderA, AdderB, {RespCarry, RespSum});
        end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen = seen | Resp0Valid | Resp1Valid;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_resp: got respvalid=%b expected 0", seen);
        end
        Req0Valid = 1'b1; Req0A = 32'h0000_0007; Req0B = 32'h0000_0008;
        tick();
        Req0Valid = 1'b0;
        tick();
        checks++;
        if ({Resp0Valid, RespSum} !== {1'b1, 32'h0000_000F}) begin
            failures++;
            $display("FAIL abort_pre_done: got rv0=%b sum=%h expected 1 0000000f", Resp0Valid, RespSum);
        end
        Reset = 1'b1;
        Resp0Ready = 1'b1;
        tick();
        Reset = 1'b0;
        Resp0Ready = 1'b0;
        checks++;
        if ({Busy, Resp0Valid, Resp1Valid, RespCarry, AdderA, AdderB, RespSum} !== 100'h0) begin
            failures++;
            $display("FAIL abort_done: got busy=%b rv=%b%b A=%h B=%h %h expected zeros",
                     Busy, Resp0Valid, Resp1Valid, AdderA, AdderB, {RespCarry, RespSum});
        end
        Req0Valid = 1'b1;
        Req1Valid = 1'b1;
        #1;
        checks++;
        if ({Req0Ready, Req1Ready} !== 2'b10) begin
            failures++;
            $display("FAIL abort_rr_reset: got %b expected 10", {Req0Ready, Req1Ready});
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [W:0] q0 [$];
        logic [W:0] q1 [$];
        logic [W:0] exp_val;
        logic       hs0, hs1;
        int         ops, cyc;
        ops = 0;
        cyc = 0;
        apply_reset();
        while (ops < 10000 && cyc < 80000) begin
            if (!Req0Valid && $urandom_range(3, 0) != 0) begin
                Req0Valid = 1'b1; Req0A = $urandom; Req0B = $urandom;
            end
            if (!Req1Valid && $urandom_range(3, 0) != 0) begin
                Req1Valid = 1'b1; Req1A = $urandom; Req1B = $urandom;
            end
            Resp0Ready = ($urandom_range(3, 0) != 0);
            Resp1Ready = ($urandom_range(3, 0) != 0);
            #1;
            hs0 = Req0Ready;
            hs1 = Req1Ready;
            if (hs0) q0.push_back({1'b0, Req0A} + {1'b0, Req0B});
            if (hs1) q1.push_back({1'b0, Req1A} + {1'b0, Req1B});
            if (Resp0Valid && Resp0Ready) begin
                checks++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("FAIL rand_p0_extra: got response %h expected none", {RespCarry, RespSum});
                end else begin
                    exp_val = q0.pop_front();
                    if ({RespCarry, RespSum} !== exp_val) begin
                        failures++;
                        $display("FAIL rand_p0_sum: got %h expected %h", {RespCarry, RespSum}, exp_val);
                    end
                end
                ops++;
            end
            if (Resp1Valid && Resp1Ready) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL rand_p1_extra: got response %h expected none", {RespCarry, RespSum});
                end else begin
                    exp_val = q1.pop_front();
                    if ({RespCarry, RespSum} !== exp_val) begin
                        failures++;
                        $display("FAIL rand_p1_sum: got %h expected %h", {RespCarry, RespSum}, exp_val);
                    end
                end
                ops++;
            end
            tick();
            cyc++;
            if (hs0) Req0Valid = 1'b0;
            if (hs1) Req1Valid = 1'b0;
        end
        checks++;
        if (ops !== 10000) begin
            failures++;
            $display("FAIL rand_timeout: got %0d ops expected 10000", ops);
        end
        checks++;
        if (q0.size() + q1.size() !== 0) begin
            failures++;
            $display("FAIL rand_lost: got %0d outstanding expected 0", q0.size() + q1.size());
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b1;
        clear_inputs();
        test_reset();
        test_port0_basic();
        test_port1_carry();
        test_round_robin();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
